// File: rtl/test_sink.sv
// Stream sink for unit benches: accepts val/rdy messages against a preloaded
// table, with optional LFSR-driven back-pressure, and reports sticky status.
module test_sink #(
  parameter int          p_msg_nbits  = 32,
  parameter int          p_max_msgs   = 64,
  parameter int          p_rand_delay = 0,
  parameter logic [31:0] p_seed       = 32'hdeadbeef,
  parameter int          p_timeout    = 10000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_en,
  input  logic [p_msg_nbits-1:0]             load_msg,
  input  logic                               start,
  input  logic                               istream_val,
  output logic                               istream_rdy,
  input  logic [p_msg_nbits-1:0]             istream_msg,
  output logic                               done,
  output logic                               failed,
  output logic                               timeout,
  output logic                               overflow,
  output logic [$clog2(p_max_msgs+1)-1:0]    num_recv,
  output logic [$clog2(p_max_msgs+1)-1:0]    err_idx,
  output logic [p_msg_nbits-1:0]             err_msg
);

  localparam int nw = $clog2(p_max_msgs + 1);
  localparam int aw = (p_max_msgs > 1) ? $clog2(p_max_msgs) : 1;
  localparam int dw = $clog2(p_rand_delay + 2);
  localparam int cw = $clog2(p_timeout + 2);
  localparam logic [31:0] lfsr_mask = 32'h80200003;

  typedef enum logic [1:0] {st_idle, st_recv, st_done} state_t;

  state_t                 state;
  logic [p_msg_nbits-1:0] tbl [p_max_msgs];
  logic [nw-1:0]          num_loaded;
  logic [31:0]            lfsr;
  logic [31:0]            lfsr_nxt;
  logic [dw-1:0]          delay;
  logic [dw-1:0]          delay_new;
  logic [cw-1:0]          cyc_cnt;
  logic [cw-1:0]          cyc_nxt;
  logic                   err_seen;
  logic                   table_full;
  logic                   accept;
  logic                   mismatch;

  assign lfsr_nxt    = (lfsr >> 1) ^ (lfsr[0] ? lfsr_mask : 32'd0);
  assign delay_new   = dw'(lfsr % 32'(p_rand_delay + 1));
  assign table_full  = (num_loaded == nw'(p_max_msgs));
  assign cyc_nxt     = cyc_cnt + cw'(1);

  // Ready never looks at istream_val, so the DUT cannot form a comb loop.
  assign istream_rdy = (state == st_recv) && (delay == '0) && (num_recv < num_loaded);
  assign accept      = istream_val && istream_rdy;
  assign mismatch    = accept && (istream_msg != tbl[num_recv[aw-1:0]]);

  always_ff @(posedge clk) begin
    if (state == st_idle && load_en && !table_full)
      tbl[num_loaded[aw-1:0]] <= load_msg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= st_idle;
      lfsr       <= p_seed;
      num_loaded <= '0;
      num_recv   <= '0;
      delay      <= '0;
      cyc_cnt    <= '0;
      err_seen   <= 1'b0;
      done       <= 1'b0;
      failed     <= 1'b0;
      timeout    <= 1'b0;
      overflow   <= 1'b0;
      err_idx    <= '0;
      err_msg    <= '0;
    end else begin
      case (state)
        st_idle: begin
          if (load_en) begin
            if (table_full) begin
              overflow <= 1'b1;
              failed   <= 1'b1;
            end else begin
              num_loaded <= num_loaded + nw'(1);
            end
          end
          if (start) begin
            state   <= st_recv;
            delay   <= delay_new;
            lfsr    <= lfsr_nxt;
            cyc_cnt <= '0;
          end
        end
        st_recv: begin
          cyc_cnt <= cyc_nxt;
          if (accept) begin
            num_recv <= num_recv + nw'(1);
            delay    <= delay_new;
            lfsr     <= lfsr_nxt;
            if (mismatch) begin
              failed <= 1'b1;
              if (!err_seen) begin
                err_seen <= 1'b1;
                err_idx  <= num_recv;
                err_msg  <= istream_msg;
              end
            end
          end else if (delay != '0) begin
            delay <= delay - dw'(1);
          end
          if (cyc_nxt > cw'(p_timeout)) begin
            timeout <= 1'b1;
            failed  <= 1'b1;
            done    <= 1'b1;
            state   <= st_done;
          end else if (num_recv == num_loaded) begin
            done  <= 1'b1;
            state <= st_done;
          end
        end
        st_done: done <= 1'b1;
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_test_sink.sv
// Bench for test_sink: two instances (no stalls / random stalls) driven with
// directed and randomized message streams, checked against a cycle model.
module tb_test_sink;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst [2];
  logic          load_en [2];
  logic          start [2];
  logic          istream_val [2];
  logic          istream_rdy [2];
  logic          done [2];
  logic          failed [2];
  logic          timeout [2];
  logic          overflow [2];
  logic [W-1:0]  load_msg [2];
  logic [W-1:0]  istream_msg [2];
  logic [W-1:0]  err_msg [2];
  logic [7:0]    num_recv [2];
  logic [7:0]    err_idx [2];
  logic [2:0]    nr0, ei0;
  logic [4:0]    nr1, ei1;

  assign num_recv[0] = 8'(nr0);
  assign err_idx[0]  = 8'(ei0);
  assign num_recv[1] = 8'(nr1);
  assign err_idx[1]  = 8'(ei1);

  test_sink #(.p_msg_nbits(W), .p_max_msgs(4), .p_rand_delay(0), .p_timeout(20)) u_dut0 (
    .clk(clk), .rst(rst[0]), .load_en(load_en[0]), .load_msg(load_msg[0]), .start(start[0]),
    .istream_val(istream_val[0]), .istream_rdy(istream_rdy[0]), .istream_msg(istream_msg[0]),
    .done(done[0]), .failed(failed[0]), .timeout(timeout[0]), .overflow(overflow[0]),
    .num_recv(nr0), .err_idx(ei0), .err_msg(err_msg[0]));

  test_sink #(.p_msg_nbits(W), .p_max_msgs(16), .p_rand_delay(3), .p_seed(32'h1234_5679),
              .p_timeout(300)) u_dut1 (
    .clk(clk), .rst(rst[1]), .load_en(load_en[1]), .load_msg(load_msg[1]), .start(start[1]),
    .istream_val(istream_val[1]), .istream_rdy(istream_rdy[1]), .istream_msg(istream_msg[1]),
    .done(done[1]), .failed(failed[1]), .timeout(timeout[1]), .overflow(overflow[1]),
    .num_recv(nr1), .err_idx(ei1), .err_msg(err_msg[1]));

  function automatic int max_of(input int k);   return (k == 0) ? 4 : 16;     endfunction
  function automatic int rd_of(input int k);    return (k == 0) ? 0 : 3;      endfunction
  function automatic int to_of(input int k);    return (k == 0) ? 20 : 300;   endfunction
  function automatic logic [31:0] seed_of(input int k);
    return (k == 0) ? 32'hdeadbeef : 32'h1234_5679;
  endfunction
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [W-1:0] ld_q [$];
  logic [W-1:0] snd_q [$];

  task automatic idle_inputs(input int k);
    load_en[k] = 1'b0; start[k] = 1'b0; istream_val[k] = 1'b0;
    load_msg[k] = '0; istream_msg[k] = '0;
  endtask

  task automatic chk_all_zero(input int k, input string ctx);
    chk($sformatf("u%0d %s rdy", k, ctx), 32'(istream_rdy[k]), 0);
    chk($sformatf("u%0d %s done", k, ctx), 32'(done[k]), 0);
    chk($sformatf("u%0d %s failed", k, ctx), 32'(failed[k]), 0);
    chk($sformatf("u%0d %s timeout", k, ctx), 32'(timeout[k]), 0);
    chk($sformatf("u%0d %s overflow", k, ctx), 32'(overflow[k]), 0);
    chk($sformatf("u%0d %s num_recv", k, ctx), 32'(num_recv[k]), 0);
    chk($sformatf("u%0d %s err_idx", k, ctx), 32'(err_idx[k]), 0);
    chk($sformatf("u%0d %s err_msg", k, ctx), 32'(err_msg[k]), 0);
  endtask

  // Loads ld_q, starts, then streams snd_q with val asserted val_pct% of cycles.
  // abort_after >= 0 asserts reset mid-cycle right after that many accepts.
  task automatic run_case(input int k, input bit do_reset, input bit start_with_last,
                          input int val_pct, input int abort_after);
    logic [31:0]  lfsr;
    logic [W-1:0] tab [$];
    logic [W-1:0] emsg;
    int stall, recv, recv_before, cyc, si, cycles, extra, eidx;
    bit in_recv, mdone, merr, mto, movf, entered, sw, val, exp_rdy, aborted;

    lfsr = seed_of(k); stall = 0; recv = 0; cyc = 0; si = 0; cycles = 0; extra = 0;
    eidx = 0; emsg = '0; in_recv = 0; mdone = 0; merr = 0; mto = 0; movf = 0;
    entered = 0; aborted = 0;
    idle_inputs(k);
    if (do_reset) begin
      rst[k] = 1'b1;
      @(posedge clk); #1;
      rst[k] = 1'b0;
      chk_all_zero(k, "reset");
    end

    for (int i = 0; i < ld_q.size(); i++) begin
      load_en[k] = 1'b1; load_msg[k] = ld_q[i];
      sw = start_with_last && (i == ld_q.size() - 1);
      start[k] = sw;
      @(posedge clk);
      if (tab.size() < max_of(k)) tab.push_back(ld_q[i]);
      else movf = 1;
      if (sw) entered = 1;
      #1;
    end
    load_en[k] = 1'b0; start[k] = 1'b0;
    chk($sformatf("u%0d overflow after load", k), 32'(overflow[k]), 32'(movf));
    if (!entered) begin
      start[k] = 1'b1;
      @(posedge clk); #1;
      start[k] = 1'b0;
    end
    stall = int'(lfsr % 32'(rd_of(k) + 1));
    lfsr = lfsr_step(lfsr);
    in_recv = 1;

    while (!aborted && extra < 4 && cycles < to_of(k) + 40) begin
      val = (si < snd_q.size()) && ($urandom_range(99) < val_pct);
      istream_val[k] = val;
      istream_msg[k] = val ? snd_q[si] : W'($urandom);
      load_en[k] = ($urandom_range(7) == 0);
      load_msg[k] = W'($urandom);
      start[k] = ($urandom_range(7) == 0);
      exp_rdy = in_recv && (stall == 0) && (recv < tab.size());
      chk($sformatf("u%0d rdy c%0d", k, cycles), 32'(istream_rdy[k]), 32'(exp_rdy));
      recv_before = recv;
      @(posedge clk);
      if (in_recv) begin
        cyc++;
        if (val && exp_rdy) begin
          if (snd_q[si] != tab[recv] && !merr) begin
            merr = 1; eidx = recv; emsg = snd_q[si];
          end
          recv++; si++;
          stall = int'(lfsr % 32'(rd_of(k) + 1));
          lfsr = lfsr_step(lfsr);
          if (recv == abort_after) aborted = 1;
        end else if (stall > 0) begin
          stall--;
        end
        if (cyc > to_of(k)) begin
          mto = 1; mdone = 1; in_recv = 0;
        end else if (recv_before == tab.size()) begin
          mdone = 1; in_recv = 0;
        end
      end else begin
        extra++;
      end
      if (!aborted) begin
        #1;
        chk($sformatf("u%0d done c%0d", k, cycles), 32'(done[k]), 32'(mdone));
        chk($sformatf("u%0d num_recv c%0d", k, cycles), 32'(num_recv[k]), 32'(recv));
      end
      cycles++;
    end

    if (aborted) begin
      #3;
      rst[k] = 1'b1;
      #1;
      chk_all_zero(k, "midrecv_rst");
      idle_inputs(k);
      @(posedge clk); #1;
      rst[k] = 1'b0;
      return;
    end

    idle_inputs(k);
    chk($sformatf("u%0d final done", k), 32'(done[k]), 32'(mdone));
    chk($sformatf("u%0d final failed", k), 32'(failed[k]), 32'(merr | movf | mto));
    chk($sformatf("u%0d final timeout", k), 32'(timeout[k]), 32'(mto));
    chk($sformatf("u%0d final overflow", k), 32'(overflow[k]), 32'(movf));
    chk($sformatf("u%0d final num_recv", k), 32'(num_recv[k]), 32'(recv));
    chk($sformatf("u%0d final err_idx", k), 32'(err_idx[k]), 32'(eidx));
    chk($sformatf("u%0d final err_msg", k), 32'(err_msg[k]), 32'(emsg));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      idle_inputs(k);
    end
    #12;

    // back-to-back, no stalls
    ld_q = {16'd1, 16'd2, 16'd3, 16'd4}; snd_q = ld_q;
    run_case(0, 1, 0, 100, -1);

    // mismatch at index 1, extra message after done is refused
    ld_q = {16'hA, 16'hB, 16'hC}; snd_q = {16'hA, 16'd5, 16'hC, 16'd7};
    run_case(1, 1, 0, 100, -1);

    // 16 messages with random stalls, repeated to show the stall pattern is seeded
    ld_q = {};
    for (int i = 0; i < 16; i++) ld_q.push_back(W'($urandom));
    snd_q = ld_q;
    run_case(1, 1, 0, 100, -1);
    run_case(1, 1, 0, 100, -1);

    // overflow: fifth load dropped
    ld_q = {16'h11, 16'h22, 16'h33, 16'h44, 16'h55}; snd_q = ld_q;
    run_case(0, 1, 0, 100, -1);

    // timeout: only one of two messages arrives
    ld_q = {16'h9, 16'h8}; snd_q = {16'h9};
    run_case(0, 1, 0, 100, -1);

    // empty table: straight to done
    ld_q = {}; snd_q = {16'h1};
    run_case(0, 1, 0, 100, -1);

    // reset mid-RECV, then reload and rerun without another reset
    ld_q = {16'h100, 16'h200, 16'h300, 16'h400}; snd_q = ld_q;
    run_case(1, 1, 1, 100, 2);
    ld_q = {16'hBEEF}; snd_q = ld_q;
    run_case(1, 0, 0, 100, -1);

    // randomized cases
    for (int t = 0; t < 14; t++) begin
      int n;
      n = $urandom_range(18);
      ld_q = {};
      for (int i = 0; i < n; i++) ld_q.push_back(W'($urandom));
      snd_q = {};
      for (int i = 0; i < n && i < 16; i++) snd_q.push_back(ld_q[i]);
      if (snd_q.size() > 0 && $urandom_range(1) == 1) begin
        int j;
        j = $urandom_range(snd_q.size() - 1);
        snd_q[j] = snd_q[j] ^ W'(1 << $urandom_range(W - 1));
      end
      if ($urandom_range(3) == 0 && snd_q.size() > 1) void'(snd_q.pop_back());
      for (int i = 0; i < $urandom_range(2); i++) snd_q.push_back(W'($urandom));
      run_case(1, 1, 1'($urandom_range(1)), (t % 3 == 0) ? 100 : ((t % 3 == 1) ? 60 : 30), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
